// File: rtl/ysyx_2022040010_div_ctrl.sv
// ysyx_2022040010_div_ctrl: RV64M divide sequencer in front of the shared iterative divider.
// Define DIV_REUSE_EN to keep the last quotient/remainder pair and answer repeats without the divider.
module ysyx_2022040010_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic [1:0]      req_op_i,
  input  logic            req_w_i,
  input  logic [XLEN-1:0] req_op1_i,
  input  logic [XLEN-1:0] req_op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            div_start_o,
  output logic            div_annul_o,
  output logic            div_signed_o,
  output logic            div_32_o,
  output logic [XLEN-1:0] div_op1_o,
  output logic [XLEN-1:0] div_op2_o,
  output logic [1:0]      div_sel_o,
  input  logic            div_ready_i,
  input  logic [XLEN-1:0] div_res_i
);
`ifdef DIV_REUSE_EN
  typedef enum logic [2:0] {IDLE, BUSY, CAP2, ABORT, RESP} state_t;
  logic [XLEN-1:0] c_op1_q, c_op1_d, c_op2_q, c_op2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  logic c_sgn_q, c_sgn_d, c_w_q, c_w_d, c_v_q, c_v_d, hit;
`else
  typedef enum logic [2:0] {IDLE, BUSY, ABORT, RESP} state_t;
`endif
  state_t state_q, state_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d, p1, p2, spec_res;
  logic [1:0] op_q, op_d;
  logic w_q, w_d, sgn, zero, ovf, acc;

  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] r);
    return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
  endfunction

  assign div_32_o = 1'b0;

  // Operands are widened first so special-case detection and the divider see one 64-bit form
  always_comb begin
    sgn = ~req_op_i[0];
    p1 = req_w_i ? {{(XLEN-32){sgn & req_op1_i[31]}}, req_op1_i[31:0]} : req_op1_i;
    p2 = req_w_i ? {{(XLEN-32){sgn & req_op2_i[31]}}, req_op2_i[31:0]} : req_op2_i;
    zero = p2 == '0;
    ovf = sgn && &p2 && p1 == (req_w_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}});
    spec_res = fmt(req_w_i, zero ? (req_op_i[1] ? p1 : {XLEN{1'b1}}) : (req_op_i[1] ? '0 : p1));
    acc = req_valid_i && !flush_i;
`ifdef DIV_REUSE_EN
    hit = c_v_q && c_op1_q == p1 && c_op2_q == p2 && c_sgn_q == sgn && c_w_q == req_w_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    op1_d = op1_q;
    op2_d = op2_q;
    op_d = op_q;
    w_d = w_q;
    res_d = res_q;
`ifdef DIV_REUSE_EN
    c_op1_d = c_op1_q;
    c_op2_d = c_op2_q;
    c_quo_d = c_quo_q;
    c_rem_d = c_rem_q;
    c_sgn_d = c_sgn_q;
    c_w_d = c_w_q;
    c_v_d = c_v_q;
`endif
    stall_o = 1'b0;
    resp_valid_o = 1'b0;
    resp_data_o = '0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    div_signed_o = 1'b0;
    div_op1_o = '0;
    div_op2_o = '0;
    div_sel_o = 2'b00;
    case (state_q)
      IDLE: begin
        stall_o = acc;
        if (acc) begin
          op1_d = p1;
          op2_d = p2;
          op_d = req_op_i;
          w_d = req_w_i;
          res_d = spec_res;
          state_d = (zero || ovf) ? RESP : BUSY;
`ifdef DIV_REUSE_EN
          if (!(zero || ovf) && hit) begin
            res_d = req_op_i[1] ? c_rem_q : c_quo_q;
            state_d = RESP;
          end
`endif
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        div_start_o = 1'b1;
        div_signed_o = ~op_q[0];
        div_op1_o = op1_q;
        div_op2_o = op2_q;
`ifdef DIV_REUSE_EN
        div_sel_o = 2'b10;
`else
        div_sel_o = op_q[1] ? 2'b01 : 2'b10;
`endif
        if (flush_i) state_d = ABORT;
        else if (div_ready_i) begin
          res_d = fmt(w_q, div_res_i);
`ifdef DIV_REUSE_EN
          state_d = CAP2;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef DIV_REUSE_EN
      // Quotient already sits in res_q; the divider now presents the remainder
      CAP2: begin
        stall_o = 1'b1;
        div_start_o = 1'b1;
        div_signed_o = ~op_q[0];
        div_op1_o = op1_q;
        div_op2_o = op2_q;
        div_sel_o = 2'b01;
        if (flush_i) state_d = ABORT;
        else begin
          c_op1_d = op1_q;
          c_op2_d = op2_q;
          c_sgn_d = ~op_q[0];
          c_w_d = w_q;
          c_quo_d = res_q;
          c_rem_d = fmt(w_q, div_res_i);
          c_v_d = 1'b1;
          res_d = op_q[1] ? fmt(w_q, div_res_i) : res_q;
          state_d = RESP;
        end
      end
`endif
      ABORT: begin
        stall_o = 1'b1;
        div_annul_o = 1'b1;
        state_d = IDLE;
      end
      RESP: begin
        resp_valid_o = !flush_i;
        resp_data_o = flush_i ? '0 : res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q <= '0;
      op2_q <= '0;
      op_q <= '0;
      w_q <= 1'b0;
      res_q <= '0;
`ifdef DIV_REUSE_EN
      c_op1_q <= '0;
      c_op2_q <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
      c_sgn_q <= 1'b0;
      c_w_q <= 1'b0;
      c_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      op_q <= op_d;
      w_q <= w_d;
      res_q <= res_d;
`ifdef DIV_REUSE_EN
      c_op1_q <= c_op1_d;
      c_op2_q <= c_op2_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
      c_sgn_q <= c_sgn_d;
      c_w_q <= c_w_d;
      c_v_q <= c_v_d;
`endif
    end
  end
endmodule

// File: doc/ysyx_2022040010_div_ctrl.md
Name: ysyx_2022040010_div_ctrl

Overview:
- Sequencer between the EX stage and the shared 64-bit iterative divider (ysyx_2022040010_div). Decodes RV64M DIV/DIVU/REM/REMU and their W forms.
- Resolves divide-by-zero and signed overflow locally, without using the divider.
- Prepares operands, drives the divider's start/annul handshake, stalls the pipeline, and formats results (including W sign-extension).
- Handles pipeline flush mid-operation.

Parameters:
- XLEN, 64, datapath width (fixed at 64; parameter exists for readability only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  divide request from EX; held stable while stall_o=1
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_w_i  in  1  1 = 32-bit (W) form
- req_op1_i  in  64  dividend
- req_op2_i  in  64  divisor
- flush_i  in  1  pipeline flush; kills the in-flight request
- stall_o  out  1  hold the pipeline
- resp_valid_o  out  1  one-cycle result strobe
- resp_data_o  out  64  formatted result
- div_start_o  out  1  divider start (level)
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  signed divide
- div_32_o  out  1  tied 0; the controller owns W formatting
- div_op1_o  out  64  prepared dividend
- div_op2_o  out  64  prepared divisor
- div_sel_o  out  2  10 = quotient, 01 = remainder
- div_ready_i  in  1  divider result ready
- div_res_i  in  64  divider selected result

Behaviour:
- Reset: clk and rst as stated above (one clock; reset synchronous, active-high). On reset, state=IDLE and every output is 0. Operand/op registers and the result register are cleared. The cached-result valid flag is cleared.
- Operand prep, latched at acceptance:
  - W signed: sign-extend bits [31:0].
  - W unsigned: zero-extend bits [31:0].
  - Non-W: pass through unchanged.
- Special cases, detected in IDLE on the prepared operands:
  - ZERO (op2 == 0): quotient = all ones; remainder = prepared op1.
  - OVF (signed, op1 == most-negative, op2 == -1): quotient = most-negative; remainder = 0.
  - W results are computed on 32 bits, then sign-extended.
- Result formatting: W ops return {32{r[31]}, r[31:0]}. This applies to DIVUW/REMUW too. Non-W ops return r unchanged.
- stall_o = (state in BUSY/CAP2/ABORT) || (state == IDLE && req_valid_i && !flush_i).
- FSM:
  - IDLE: if req_valid_i && !flush_i, latch the request. Special case → RESP. Otherwise → BUSY.
  - BUSY: div_start_o=1, operands and div_signed_o driven from the latches, div_sel_o per op.
    - flush_i → ABORT.
    - div_ready_i → capture the formatted div_res_i, then → RESP (→ CAP2 with the optional feature).
    - div_ready_i is ignored in every other state.
  - ABORT: exactly 1 cycle, div_start_o=0, div_annul_o=1, then → IDLE. No response is produced.
  - RESP: exactly 1 cycle, div_start_o=0 (this releases the divider), resp_valid_o=1 with the result, then → IDLE.
    - flush_i in RESP: resp_valid_o is forced 0, then → IDLE.
- Divider timing: the divider is free again by the IDLE cycle following RESP or ABORT, so back-to-back requests are legal.
- Latency:
  - Special cases: resp_valid_o 1 cycle after acceptance.
  - Divider path: resp_valid_o 1 cycle after div_ready_i is seen (2 cycles with the optional feature).
- The divider never receives op2 == 0.
- Reset mid-operation: reset returns to IDLE immediately, with no response. The divider shares rst.

Optional Feature:
- Macro: DIV_REUSE_EN.
- With the macro defined:
  - BUSY drives div_sel_o=10.
  - On div_ready_i → CAP2. CAP2 holds div_start_o=1 and div_sel_o=01, captures the remainder, then → RESP.
  - The controller stores {op1, op2, signed, w, quotient, remainder, valid}, with results pre-formatted.
  - A later non-special request matching op1/op2/signed/w returns the requested half via IDLE→RESP and never asserts div_start_o.
  - The cache is written only by completed divider operations. It is cleared only by reset.
- Without the macro: no CAP2 state, no cache, and div_sel_o follows the op.

Test Plan:
- DIV: op1=0xFFFFFFFFFFFFFFEC (-20), op2=3 → resp_data_o=0xFFFFFFFFFFFFFFFA. REM with the same operands → 0xFFFFFFFFFFFFFFFE. Exactly one resp_valid_o pulse each; stall_o is low in the RESP cycle.
- DIVUW: op1=0x12345678FFFFFFFF, op2=1 → div_op1_o=0x00000000FFFFFFFF, resp_data_o=0xFFFFFFFFFFFFFFFF. REMUW of 10 by 3 → 0x1.
- DIVU 7/0 → 0xFFFFFFFFFFFFFFFF. REM 7/0 → 0x7. REMW of op1=0x00000000_80000005 by 0 → 0xFFFFFFFF80000005. In all three, resp_valid_o comes 1 cycle after acceptance and div_start_o stays 0.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → 0x8000000000000000. REMW 0x80000000 / 0xFFFFFFFF → 0. The divider is not started.
- flush_i pulsed 10 cycles into BUSY → one div_annul_o pulse, no resp_valid_o, then IDLE. A following DIVU 100/7 → 14. Also assert rst mid-BUSY → all outputs are 0 next cycle.
- With DIV_REUSE_EN: DIV 100/7 → 14, then REM 100/7 → 2, returned 1 cycle after acceptance with no div_start_o. Then REM 100/9 → divider used, result 1.
